// File: rtl/servo_motion_ctrl.sv
// Pan/tilt servo sequencer: picks the duty count each pwm samples at its period
// boundary, in centre-hold, slew-limited tracking, or autonomous scan modes.
module servo_motion_ctrl #(
  parameter int DC_MIN       = 100_000,
  parameter int DC_MAX       = 200_000,
  parameter int DC_CENTER    = 150_000,
  parameter int MAX_STEP     = 2_000,
  parameter int SCAN_STEP    = 1_000,
  parameter int LOST_PERIODS = 50
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [1:0]  mode_in,
  input  logic [20:0] target_x,
  input  logic [20:0] target_y,
  input  logic        target_valid,
  input  logic        ready_x,
  input  logic        ready_y,
  output logic [20:0] dc_x,
  output logic [20:0] dc_y,
  output logic [1:0]  state_out,
  output logic        lost_out
);

  typedef enum logic [1:0] {
    ST_CENTER = 2'b00,
    ST_TRACK  = 2'b01,
    ST_SCAN   = 2'b10,
    ST_LOST   = 2'b11
  } state_t;

  localparam int                CNT_W  = $clog2(LOST_PERIODS + 1);
  localparam logic [20:0]       MIN_V  = 21'(DC_MIN);
  localparam logic [20:0]       MAX_V  = 21'(DC_MAX);
  localparam logic [20:0]       CTR_V  = 21'(DC_CENTER);
  localparam logic signed [21:0] STEP_S = 22'(MAX_STEP);
  localparam logic [21:0]       SCAN_V = 22'(SCAN_STEP);

  state_t             state_reg;
  logic [20:0]        dc_x_reg, dc_y_reg;
  logic [20:0]        latch_x_reg, latch_y_reg;
  logic [CNT_W-1:0]   lost_cnt_reg, lost_cnt_next;
  logic               scan_up_reg;
  logic               lost_reg;
  logic [21:0]        scan_up_sum;
  logic [20:0]        scan_x_next;
  logic               scan_flip;
  logic               lost_hit;

  function automatic logic [20:0] clamp_dc(input logic [20:0] v);
    logic [20:0] r;
    r = v;
    if (v < MIN_V) r = MIN_V;
    else if (v > MAX_V) r = MAX_V;
    return r;
  endfunction

  // Move cur toward tgt by at most MAX_STEP; difference taken signed at 22 bits.
  function automatic logic [20:0] slew(input logic [20:0] cur, input logic [20:0] tgt);
    logic signed [21:0] diff;
    logic signed [21:0] sum;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    if (diff > STEP_S) diff = STEP_S;
    else if (diff < -STEP_S) diff = -STEP_S;
    sum = $signed({1'b0, cur}) + diff;
    return sum[20:0];
  endfunction

  always_comb begin
    scan_up_sum = {1'b0, dc_x_reg} + SCAN_V;
    scan_x_next = dc_x_reg;
    scan_flip   = 1'b0;
    if (scan_up_reg) begin
      if (scan_up_sum > {1'b0, MAX_V}) begin
        scan_x_next = MAX_V;
        scan_flip   = 1'b1;
      end else begin
        scan_x_next = scan_up_sum[20:0];
      end
    end else begin
      if ({1'b0, dc_x_reg} < ({1'b0, MIN_V} + SCAN_V)) begin
        scan_x_next = MIN_V;
        scan_flip   = 1'b1;
      end else begin
        scan_x_next = 21'({1'b0, dc_x_reg} - SCAN_V);
      end
    end
  end

  // A fresh detection outranks a ready_x tick when both land in the same cycle.
  always_comb begin
    lost_cnt_next = lost_cnt_reg;
    if (target_valid) lost_cnt_next = '0;
    else if (ready_x) lost_cnt_next = lost_cnt_reg + CNT_W'(1);
    lost_hit = (lost_cnt_next == CNT_W'(LOST_PERIODS));
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg    <= ST_CENTER;
      dc_x_reg     <= CTR_V;
      dc_y_reg     <= CTR_V;
      latch_x_reg  <= CTR_V;
      latch_y_reg  <= CTR_V;
      lost_cnt_reg <= '0;
      scan_up_reg  <= 1'b1;
      lost_reg     <= 1'b0;
    end else begin
      if (target_valid) begin
        latch_x_reg <= clamp_dc(target_x);
        latch_y_reg <= clamp_dc(target_y);
      end
      case (state_reg)
        ST_CENTER: begin
          if (ready_x) dc_x_reg <= slew(dc_x_reg, CTR_V);
          if (ready_y) dc_y_reg <= slew(dc_y_reg, CTR_V);
          if (mode_in == 2'b01) begin
            state_reg    <= ST_TRACK;
            lost_cnt_reg <= '0;
          end else if (mode_in == 2'b10) begin
            state_reg <= ST_SCAN;
            lost_reg  <= 1'b0;
          end
        end
        ST_TRACK: begin
          if (ready_x) dc_x_reg <= slew(dc_x_reg, latch_x_reg);
          if (ready_y) dc_y_reg <= slew(dc_y_reg, latch_y_reg);
          lost_cnt_reg <= lost_cnt_next;
          if (mode_in == 2'b00 || mode_in == 2'b11) begin
            state_reg <= ST_CENTER;
          end else if (mode_in == 2'b10) begin
            state_reg <= ST_SCAN;
            lost_reg  <= 1'b0;
          end else if (lost_hit) begin
            state_reg <= ST_LOST;
            lost_reg  <= 1'b1;
          end
        end
        ST_LOST: begin
          // Sweep toward whichever end of travel has more room; ties go up.
          scan_up_reg <= ((MAX_V - dc_x_reg) >= (dc_x_reg - MIN_V));
          state_reg   <= ST_SCAN;
        end
        default: begin
          if (ready_y) dc_y_reg <= slew(dc_y_reg, CTR_V);
          if (ready_x) begin
            dc_x_reg <= scan_x_next;
            if (scan_flip) scan_up_reg <= ~scan_up_reg;
          end
          if (mode_in == 2'b00 || mode_in == 2'b11) begin
            state_reg <= ST_CENTER;
            lost_reg  <= 1'b0;
          end else if (mode_in == 2'b10) begin
            lost_reg <= 1'b0;
          end else if (!lost_reg || target_valid) begin
            // Mode 01: an operator sweep hands straight back to tracking, a
            // timeout sweep waits for the next detection.
            state_reg    <= ST_TRACK;
            lost_cnt_reg <= '0;
            lost_reg     <= 1'b0;
          end
        end
      endcase
    end
  end

  assign dc_x      = dc_x_reg;
  assign dc_y      = dc_y_reg;
  assign state_out = state_reg;
  assign lost_out  = lost_reg;

endmodule

// File: tb/tb_servo_motion_ctrl.sv
// Bench for servo_motion_ctrl: directed test-plan steps followed by a random phase,
// every cycle compared against a behavioural model of the mode rules.
module tb_servo_motion_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [1:0]  mode_in = 2'b00;
  logic [20:0] target_x = '0;
  logic [20:0] target_y = '0;
  logic        target_valid = 1'b0;
  logic        ready_x = 1'b0;
  logic        ready_y = 1'b0;
  logic [20:0] dc_x, dc_y;
  logic [1:0]  state_out;
  logic        lost_out;

  int n_asserts = 0;
  int n_fails   = 0;

  // Behavioural model: state codes as seen on state_out, values as plain ints.
  int m_state, m_dcx, m_dcy, m_lx, m_ly, m_cnt;
  bit m_up, m_lost;

  servo_motion_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .mode_in(mode_in),
    .target_x(target_x), .target_y(target_y), .target_valid(target_valid),
    .ready_x(ready_x), .ready_y(ready_y),
    .dc_x(dc_x), .dc_y(dc_y), .state_out(state_out), .lost_out(lost_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic int toward(int cur, int tgt, int lim);
    int d = tgt - cur;
    if (d > lim) d = lim;
    if (d < -lim) d = -lim;
    return cur + d;
  endfunction

  function automatic int clampi(int v);
    if (v < 100000) return 100000;
    if (v > 200000) return 200000;
    return v;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    int nlx, nly, nx;
    if (rst_in) begin
      m_state = 0; m_dcx = 150000; m_dcy = 150000; m_lx = 150000; m_ly = 150000;
      m_cnt = 0; m_up = 1; m_lost = 0;
      return;
    end
    nlx = target_valid ? clampi(int'(target_x)) : m_lx;
    nly = target_valid ? clampi(int'(target_y)) : m_ly;
    case (m_state)
      0: begin
        if (ready_x) m_dcx = toward(m_dcx, 150000, 2000);
        if (ready_y) m_dcy = toward(m_dcy, 150000, 2000);
        if (mode_in == 1) begin m_state = 1; m_cnt = 0; end
        else if (mode_in == 2) begin m_state = 2; m_lost = 0; end
      end
      1: begin
        if (ready_x) m_dcx = toward(m_dcx, m_lx, 2000);
        if (ready_y) m_dcy = toward(m_dcy, m_ly, 2000);
        if (target_valid) m_cnt = 0;
        else if (ready_x) m_cnt = m_cnt + 1;
        if (mode_in == 0 || mode_in == 3) m_state = 0;
        else if (mode_in == 2) begin m_state = 2; m_lost = 0; end
        else if (m_cnt == 50) begin m_state = 3; m_lost = 1; end
      end
      3: begin
        m_up = (200000 - m_dcx) >= (m_dcx - 100000);
        m_state = 2;
      end
      default: begin
        if (ready_y) m_dcy = toward(m_dcy, 150000, 2000);
        if (ready_x) begin
          nx = m_up ? m_dcx + 1000 : m_dcx - 1000;
          if (nx > 200000) begin nx = 200000; m_up = 0; end
          else if (nx < 100000) begin nx = 100000; m_up = 1; end
          m_dcx = nx;
        end
        if (mode_in == 0 || mode_in == 3) begin m_state = 0; m_lost = 0; end
        else if (mode_in == 2) m_lost = 0;
        else if (!m_lost || target_valid) begin m_state = 1; m_cnt = 0; m_lost = 0; end
      end
    endcase
    m_lx = nlx;
    m_ly = nly;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk_in);
    #1;
    chk("dc_x", 32'(dc_x), 32'(m_dcx));
    chk("dc_y", 32'(dc_y), 32'(m_dcy));
    chk("state", 32'(state_out), 32'(m_state));
    chk("lost", 32'(lost_out), 32'(m_lost));
    chk("range", 32'(dc_x >= 100000 && dc_x <= 200000 && dc_y >= 100000 && dc_y <= 200000), 32'd1);
    target_valid = 1'b0;
    ready_x = 1'b0;
    ready_y = 1'b0;
  endtask

  task automatic pulse(int n, int gap, bit rx, bit ry);
    for (int i = 0; i < n; i++) begin
      ready_x = rx;
      ready_y = ry;
      tick();
      repeat (gap - 1) tick();
    end
  endtask

  task automatic give_target(int tx, int ty);
    target_x = 21'(tx);
    target_y = 21'(ty);
    target_valid = 1'b1;
    tick();
  endtask

  initial begin
    int tv_rate;
    // Reset state
    repeat (3) tick();
    chk("rst_dc_x", 32'(dc_x), 32'd150000);
    chk("rst_state", 32'(state_out), 32'd0);
    chk("rst_lost", 32'(lost_out), 32'd0);
    rst_in = 1'b0;

    // 1: track toward 160000 in 2000 steps, then hold
    mode_in = 2'b01;
    tick();
    chk("t1_track", 32'(state_out), 32'd1);
    give_target(160000, 150000);
    for (int i = 0; i < 7; i++) begin
      ready_x = 1'b1;
      tick();
      chk("t1_step", 32'(dc_x), 32'((152000 + 2000 * i > 160000) ? 160000 : 152000 + 2000 * i));
      repeat (9) tick();
    end

    // 2: below-range target clamps to DC_MIN
    give_target(50000, 150000);
    pulse(33, 10, 1, 0);
    chk("t2_floor", 32'(dc_x), 32'd100000);

    // 3: 50 silent ready_x periods -> LOST for one cycle -> SCAN
    give_target(130000, 150000);
    pulse(49, 10, 1, 0);
    chk("t3_still_track", 32'(state_out), 32'd1);
    ready_x = 1'b1;
    tick();
    chk("t3_lost_state", 32'(state_out), 32'd3);
    chk("t3_lost_flag", 32'(lost_out), 32'd1);
    tick();
    chk("t3_scan_state", 32'(state_out), 32'd2);
    chk("t3_scan_flag", 32'(lost_out), 32'd1);
    repeat (3) tick();
    give_target(140000, 150000);
    chk("t3_reacquire", 32'(state_out), 32'd1);
    chk("t3_lost_clear", 32'(lost_out), 32'd0);

    // 4: operator scan saturates at DC_MAX and reverses
    rst_in = 1'b1; mode_in = 2'b00;
    repeat (2) tick();
    rst_in = 1'b0; mode_in = 2'b01;
    tick();
    give_target(199500, 180000);
    pulse(26, 10, 1, 1);
    chk("t4_pre", 32'(dc_x), 32'd199500);
    chk("t4_pre_y", 32'(dc_y), 32'd180000);
    mode_in = 2'b10;
    tick();
    chk("t4_scan", 32'(state_out), 32'd2);
    ready_x = 1'b1;
    tick();
    chk("t4_sat", 32'(dc_x), 32'd200000);
    repeat (9) tick();
    ready_x = 1'b1;
    tick();
    chk("t4_flip", 32'(dc_x), 32'd199000);
    pulse(20, 10, 0, 1);
    chk("t4_y_center", 32'(dc_y), 32'd150000);

    // 5: coincident ready_x/ready_y/target_valid, then reset mid-ramp
    mode_in = 2'b00; tick();
    mode_in = 2'b01; tick();
    give_target(120000, 170000);
    pulse(10, 10, 1, 0);
    chk("t5_pre", 32'(dc_x), 32'd179000);
    ready_x = 1'b1; ready_y = 1'b1;
    give_target(120000, 170000);
    chk("t5_both_x", 32'(dc_x), 32'd177000);
    chk("t5_both_y", 32'(dc_y), 32'd152000);
    pulse(49, 10, 1, 0);
    chk("t5_cnt_cleared", 32'(state_out), 32'd1);
    give_target(190000, 150000);
    pulse(3, 10, 1, 0);
    rst_in = 1'b1; ready_x = 1'b1; mode_in = 2'b00;
    tick();
    chk("t5_rst_x", 32'(dc_x), 32'd150000);
    chk("t5_rst_y", 32'(dc_y), 32'd150000);
    chk("t5_rst_state", 32'(state_out), 32'd0);
    rst_in = 1'b0;

    // 6: TRACK -> CENTER ramps back to DC_CENTER
    mode_in = 2'b01;
    tick();
    give_target(180000, 150000);
    pulse(15, 10, 1, 0);
    chk("t6_at_180k", 32'(dc_x), 32'd180000);
    mode_in = 2'b00;
    tick();
    chk("t6_center", 32'(state_out), 32'd0);
    ready_x = 1'b1;
    tick();
    chk("t6_first", 32'(dc_x), 32'd178000);
    pulse(16, 10, 1, 0);
    chk("t6_rest", 32'(dc_x), 32'd150000);

    // Random phase against the model
    for (int c = 0; c < 5000; c++) begin
      tv_rate = (c < 2500) ? 30 : 1500;
      if ($urandom_range(199) == 0) mode_in = 2'($urandom_range(3));
      if ($urandom_range(tv_rate - 1) == 0) begin
        target_valid = 1'b1;
        target_x = 21'($urandom_range(1) == 1 ? $urandom_range(210000, 90000) : $urandom_range(2097151));
        target_y = 21'($urandom_range(1) == 1 ? $urandom_range(210000, 90000) : $urandom_range(2097151));
      end
      ready_x = ($urandom_range(14) == 0);
      ready_y = ($urandom_range(16) == 0);
      rst_in  = ($urandom_range(1999) == 0);
      tick();
    end
    rst_in = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule

// File: doc/servo_motion_ctrl.md
Name: servo_motion_ctrl

Overview:
- Sequences the pan (x) and tilt (y) servo PWM generators.
- Takes the predicted PWM targets from the centre-of-mass predictor and decides what duty-count each servo gets, and when.
- Modes: centre hold, slew-limited tracking, and an autonomous scan sweep entered on operator request or after the target is lost.
- Sits between the predictor and the two pwm instances; its outputs feed their dc_in and it consumes their ready pulses.

Parameters:
- DC_MIN, 100_000, lowest legal duty count (clk_in cycles).
- DC_MAX, 200_000, highest legal duty count.
- DC_CENTER, 150_000, rest/centre duty count.
- MAX_STEP, 2_000, largest change applied to one axis per ready pulse in tracking.
- SCAN_STEP, 1_000, x increment per ready_x pulse in scan.
- LOST_PERIODS, 50, ready_x pulses without target_valid before TRACK falls back to SCAN.

Ports:
- clk_in, input, 1, camera-domain clock.
- rst_in, input, 1, synchronous active-high reset.
- mode_in, input, 2, 00 = centre, 01 = track, 10 = scan, 11 = centre.
- target_x, input, 21, predicted x duty count.
- target_y, input, 21, predicted y duty count.
- target_valid, input, 1, single-cycle pulse: target_x/y hold a fresh detection.
- ready_x, input, 1, pulse from x pwm: the period boundary where dc is sampled.
- ready_y, input, 1, same for the y pwm.
- dc_x, output, 21, duty count to the x pwm.
- dc_y, output, 21, duty count to the y pwm.
- state_out, input-free output, 2, current state (00 CENTER, 01 TRACK, 10 SCAN, 11 LOST) for debug LEDs.
- lost_out, output, 1, high while in LOST or in a timeout-entered SCAN.

Behaviour:
Reset:
- rst_in is synchronous and active-high; single clock clk_in.
- Reset values: dc_x = dc_y = DC_CENTER; state = CENTER; lost_out = 0; lost counter = 0; scan direction = up; target latch = DC_CENTER for both axes.
- Reset asserted mid-sweep or mid-slew overrides everything on the next edge.

Target latch:
- On target_valid, target_x/y are clamped to [DC_MIN, DC_MAX] and registered.
- The latch is updated in every state, so a TRACK entry uses the most recent detection.

States:
- CENTER: on each ready_x (ready_y), dc_x (dc_y) moves toward DC_CENTER by at most MAX_STEP.
  - mode 01 -> TRACK; mode 10 -> SCAN.
- TRACK: on ready_x, dc_x <= dc_x + clamp(latch_x - dc_x, -MAX_STEP, +MAX_STEP). y is handled the same way on ready_y.
  - Difference is computed signed at 22 bits.
  - The lost counter clears on target_valid and increments on ready_x otherwise. If both occur in the same cycle, the clear wins.
  - Counter reaches LOST_PERIODS -> LOST.
  - mode 00/11 -> CENTER; mode 10 -> SCAN with lost_out = 0.
- LOST: one-cycle state. Sets lost_out = 1 and the scan direction toward the farther bound from dc_x, then -> SCAN.
- SCAN:
  - dc_y slews toward DC_CENTER as in CENTER.
  - On ready_x, dc_x steps by SCAN_STEP in the current direction. If the result would pass DC_MAX (DC_MIN), dc_x saturates at the bound and the direction flips. There is no wrap.
  - Timeout-entered SCAN: target_valid -> TRACK, lost counter cleared, lost_out = 0.
  - Operator-entered SCAN (mode 10) stays in SCAN regardless of targets.
  - Any mode other than 10 or 01 -> CENTER. If mode is 01 during a timeout-entered scan, SCAN is held until a target arrives.

Timing:
- Mode changes take effect on the next clock edge.
- dc_x/dc_y update only in the cycle after the corresponding ready pulse, so each pwm period sees a stable value.
- ready_x and ready_y are independent and may coincide; both axes update in that cycle.
- A ready pulse in the same cycle as a state transition applies the outgoing state's rule.

Invariant:
- dc_x and dc_y always lie in [DC_MIN, DC_MAX].

Test Plan:
1. Reset, mode 01, target_valid with target_x = 160_000, ready_x every 1000 clk -> dc_x steps 152_000, 154_000 … and reaches 160_000 after 5 pulses, then holds.
2. Mode 01, target_x = 50_000 -> latch clamps to 100_000; dc_x ramps down by 2_000 per ready_x and stops at 100_000, never below.
3. Mode 01, no target_valid for 50 ready_x pulses -> state_out = 11 for one cycle, then 10; lost_out = 1. Next target_valid -> state 01, lost_out = 0.
4. Mode 10 from dc_x = 199_500 scanning up -> next ready_x gives dc_x = 200_000 and the direction flips; the following pulse gives 199_000. dc_y converges to 150_000.
5. ready_x, ready_y and target_valid in the same cycle during TRACK -> both axes update, lost counter = 0. Assert rst_in mid-ramp -> next cycle dc_x = dc_y = 150_000, state_out = 00.
6. mode_in 01 -> 00 while dc_x = 180_000 -> state CENTER next edge; dc_x decreases 2_000 per ready_x to 150_000.
